// File: rtl/regfile_port_arb_pkg.sv
// ============================================================================
// Module  : regfile_port_arb_pkg
// Purpose : Shared constants and types for the register-file port arbiter.
//           Carries the register-file write-enable polarity, default sizes
//           and the per-cycle arbitration decision encoding.
// Ports   : none (package)
// Config  : RFARB_FWD_EN (consumed by regfile_port_arb)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_port_arb_pkg;

  // Register-file we_ is active low.
  localparam logic c_ENABLE_  = 1'b0;
  localparam logic c_DISABLE_ = 1'b1;

  localparam int c_ADDR_W   = 5;
  localparam int c_DATA_W   = 32;
  localparam int c_WQ_DEPTH = 4;

  // Which requester owns the shared rf_addr bus this cycle.
  typedef enum logic [1:0] {
    RFARB_IDLE  = 2'd0,
    RFARB_READ  = 2'd1,
    RFARB_DRAIN = 2'd2,
    RFARB_FULL  = 2'd3
  } arb_sel_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_port_arb_if.sv
// ============================================================================
// Module  : regfile_port_arb_if
// Purpose : Bundles the write-request, read-request, register-file and
//           status signals of the port arbiter.
// Ports   : slave  - arbiter side (drives ready/rdata/rf_*/wq_count)
//           master - client/regfile side (drives requests and rf_d_out)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_port_arb_if
  import regfile_port_arb_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DATA_W   = c_DATA_W,
  parameter int WQ_DEPTH = c_WQ_DEPTH
);
  localparam int CNT_W = cnt_width(WQ_DEPTH);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_d_in;
  logic              rf_we_;
  logic [DATA_W-1:0] rf_d_out;
  logic [CNT_W-1:0]  wq_count;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rf_d_out,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata, rf_addr, rf_d_in,
           rf_we_, wq_count
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rf_d_out,
    input  wr_ready, rd_ready, rd_rvalid, rd_rdata, rf_addr, rf_d_in,
           rf_we_, wq_count
  );

endinterface

`default_nettype wire

// File: rtl/regfile_wq_fifo.sv
// ============================================================================
// Module  : regfile_wq_fifo
// Purpose : In-order write queue with full CAM lookup. Returns the head
//           entry for draining and the youngest queued entry whose address
//           matches the lookup address.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           i_push/addr/data  - enqueue (caller guarantees not full)
//           i_pop             - dequeue head (caller guarantees not empty)
//           i_lookup_addr     - CAM search key
//           o_count, o_full   - occupancy
//           o_head_addr/data  - oldest entry
//           o_hit, o_hit_data - youngest matching entry
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wq_fifo
  import regfile_port_arb_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DATA_W   = c_DATA_W,
  parameter int WQ_DEPTH = c_WQ_DEPTH
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          i_push,
  input  wire logic [ADDR_W-1:0]             i_push_addr,
  input  wire logic [DATA_W-1:0]             i_push_data,
  input  wire logic                          i_pop,
  input  wire logic [ADDR_W-1:0]             i_lookup_addr,
  output logic [cnt_width(WQ_DEPTH)-1:0]     o_count,
  output logic                               o_full,
  output logic [ADDR_W-1:0]                  o_head_addr,
  output logic [DATA_W-1:0]                  o_head_data,
  output logic                               o_hit,
  output logic [DATA_W-1:0]                  o_hit_data
);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = cnt_width(WQ_DEPTH);

  logic [ADDR_W-1:0] r_addr [WQ_DEPTH];
  logic [DATA_W-1:0] r_data [WQ_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_idx;

  // Storage is not reset; validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match overwrites earlier ones,
  // leaving the youngest matching entry selected.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int k = 0; k < WQ_DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_addr[w_idx] == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_idx];
      end
    end
  end

  assign o_count     = r_count;
  assign o_full      = (r_count == CNT_W'(WQ_DEPTH));
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

endmodule

`default_nettype wire

// File: rtl/regfile_port_arb.sv
// ============================================================================
// Module  : regfile_port_arb
// Purpose : Arbitrates the single address port of the register file between
//           read requests and a queue of buffered write-backs. Reads win
//           unless the queue is full or (without forwarding) the read hits a
//           queued write. Read data returns one cycle after grant.
// Ports   : clk, reset - clock, synchronous active-high reset
//           bus        - regfile_port_arb_if.slave (requests, rf_*, status)
// Config  : RFARB_FWD_EN - when defined, reads hitting the queue are granted
//           and return the youngest matching queued data; when undefined a
//           hit stalls the read until the matching writes have drained.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arb
  import regfile_port_arb_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DATA_W   = c_DATA_W,
  parameter int WQ_DEPTH = c_WQ_DEPTH
) (
  input  wire logic          clk,
  input  wire logic          reset,
  regfile_port_arb_if.slave  bus
);
  localparam int CNT_W = cnt_width(WQ_DEPTH);

  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_push;
  logic              w_pop;
  logic              w_grant;
  logic              w_hazard;
  logic [DATA_W-1:0] w_rd_sel;
  arb_sel_e          w_sel;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  assign bus.wr_ready = (w_count < CNT_W'(WQ_DEPTH));
  // The queue captures this at posedge; the entry is invisible to lookup and
  // drain until the following cycle, so a same-cycle read sees the old value.
  assign w_push       = bus.wr_valid & bus.wr_ready;

  regfile_wq_fifo #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WQ_DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_addr   (bus.wr_addr),
    .i_push_data   (bus.wr_data),
    .i_pop         (w_pop),
    .i_lookup_addr (bus.rd_addr),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

`ifdef RFARB_FWD_EN
  assign w_hazard = 1'b0;
  assign w_rd_sel = w_hit ? w_hit_data : bus.rf_d_out;
`else
  logic w_unused_hit_data;
  assign w_hazard          = w_hit;
  assign w_rd_sel          = bus.rf_d_out;
  assign w_unused_hit_data = ^w_hit_data;
`endif

  // First matching rule wins; reset forces idle so no write reaches the
  // regfile while the queue is being discarded.
  always_comb begin
    w_sel = RFARB_IDLE;
    if (reset)                           w_sel = RFARB_IDLE;
    else if (w_full)                     w_sel = RFARB_FULL;
    else if (bus.rd_valid && !w_hazard)  w_sel = RFARB_READ;
    else if (w_count != '0)              w_sel = RFARB_DRAIN;
  end

  always_comb begin
    bus.rf_addr  = '0;
    bus.rf_d_in  = '0;
    bus.rf_we_   = c_DISABLE_;
    bus.rd_ready = 1'b0;
    w_pop        = 1'b0;
    case (w_sel)
      RFARB_FULL, RFARB_DRAIN: begin
        bus.rf_addr = w_head_addr;
        bus.rf_d_in = w_head_data;
        bus.rf_we_  = c_ENABLE_;
        w_pop       = 1'b1;
      end
      RFARB_READ: begin
        bus.rf_addr  = bus.rd_addr;
        bus.rd_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_grant = bus.rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_grant;
      if (w_grant) r_rdata <= w_rd_sel;
    end
  end

  assign bus.rd_rvalid = r_rvalid;
  assign bus.rd_rdata  = r_rdata;
  assign bus.wq_count  = w_count;

endmodule

`default_nettype wire
